// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared types and defaults for the vector register file
package vec_pkg;

  localparam int VEC_LANES      = 16;
  localparam int VEC_LANE_WIDTH = 32;

  typedef logic [VEC_LANE_WIDTH-1:0] vec_lane_t;
  typedef vec_lane_t [VEC_LANES-1:0] vec_t;
  typedef logic [VEC_LANES-1:0]      vec_mask_t;

  typedef enum logic {
    CLEAR,
    READY
  } vec_rf_state_e;

endpackage

// File: rtl/vec_lane_bank.sv
// rtl/vec_lane_bank.sv - one lane of storage with registered, forwarding read ports
module vec_lane_bank
  import vec_pkg::*;
#(
  parameter int INDEX_WIDTH = 3,
  parameter int LANE_WIDTH  = VEC_LANE_WIDTH,
  parameter int READ_PORTS  = 2
) (
  input  logic                                  i_clk,
  input  logic                                  i_zero_reads,
  input  logic                                  i_write_enable,
  input  logic [INDEX_WIDTH-1:0]                i_write_addr,
  input  logic [LANE_WIDTH-1:0]                 i_write_data,
  input  logic [READ_PORTS-1:0][INDEX_WIDTH-1:0] i_read_addr,
  output logic [READ_PORTS-1:0][LANE_WIDTH-1:0]  o_read_data
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  logic [LANE_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_write_enable) begin
      mem[i_write_addr] <= i_write_data;
    end
  end

  // A read hitting the entry being written returns the incoming data, so
  // the output always reflects the entry as of the end of the cycle.
  always_ff @(posedge i_clk) begin
    for (int p = 0; p < READ_PORTS; p++) begin
      if (i_zero_reads) begin
        o_read_data[p] <= '0;
      end else if (i_write_enable && (i_write_addr == i_read_addr[p])) begin
        o_read_data[p] <= i_write_data;
      end else begin
        o_read_data[p] <= mem[i_read_addr[p]];
      end
    end
  end

endmodule

// File: rtl/vec_regfile.sv
// rtl/vec_regfile.sv - multi-port masked vector register file with post-reset clear
module vec_regfile
  import vec_pkg::*;
#(
  parameter int LANES       = VEC_LANES,
  parameter int LANE_WIDTH  = VEC_LANE_WIDTH,
  parameter int INDEX_WIDTH = 3,
  parameter int READ_PORTS  = 2
) (
  input  logic                                             i_clk,
  input  logic                                             i_rst,
  input  logic [READ_PORTS-1:0][INDEX_WIDTH-1:0]           i_read_addr,
  output logic [READ_PORTS-1:0][LANES-1:0][LANE_WIDTH-1:0] o_read_data,
  input  logic                                             i_write_enable,
  input  logic [INDEX_WIDTH-1:0]                           i_write_addr,
  input  logic [LANES-1:0]                                 i_write_mask,
  input  logic [LANES-1:0][LANE_WIDTH-1:0]                 i_write_data,
  output logic                                             o_busy
);

  localparam logic [INDEX_WIDTH-1:0] LAST_ENTRY = '1;

  vec_rf_state_e          state_q, state_d;
  logic [INDEX_WIDTH-1:0] count_q, count_d;
  logic                   clearing;
  logic                   zero_reads;
  logic                   user_we;
  logic [INDEX_WIDTH-1:0] bank_waddr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= CLEAR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    clearing = 1'b0;
    case (state_q)
      CLEAR: begin
        clearing = 1'b1;
        count_d  = count_q + 1'b1;
        if (count_q == LAST_ENTRY) begin
          state_d = READY;
        end
      end
      READY: ;
      default: state_d = CLEAR;
    endcase
  end

  assign o_busy     = clearing;
  assign zero_reads = i_rst | clearing;
  assign user_we    = i_write_enable & ~clearing & ~i_rst;
  assign bank_waddr = clearing ? count_q : i_write_addr;

  // While clearing, every bank writes zero to the counter entry regardless of mask.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [READ_PORTS-1:0][LANE_WIDTH-1:0] lane_rd;

    vec_lane_bank #(
      .INDEX_WIDTH (INDEX_WIDTH),
      .LANE_WIDTH  (LANE_WIDTH),
      .READ_PORTS  (READ_PORTS)
    ) u_bank (
      .i_clk          (i_clk),
      .i_zero_reads   (zero_reads),
      .i_write_enable (clearing | (user_we & i_write_mask[k])),
      .i_write_addr   (bank_waddr),
      .i_write_data   (clearing ? {LANE_WIDTH{1'b0}} : i_write_data[k]),
      .i_read_addr    (i_read_addr),
      .o_read_data    (lane_rd)
    );

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
      assign o_read_data[p][k] = lane_rd[p];
    end
  end

endmodule

// File: tb/tb_vec_regfile.sv
// tb/tb_vec_regfile.sv - self-checking bench for vec_regfile
module tb_vec_regfile;
  localparam int LANES = 16;
  localparam int LW    = 32;
  localparam int IW    = 3;
  localparam int RP    = 2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                             rst;
  logic [RP-1:0][IW-1:0]            raddr;
  logic [RP-1:0][LANES-1:0][LW-1:0] rdata;
  logic                             we;
  logic [IW-1:0]                    waddr;
  logic [LANES-1:0]                 wmask;
  logic [LANES-1:0][LW-1:0]         wdata;
  logic                             busy;

  vec_regfile #(
    .LANES       (LANES),
    .LANE_WIDTH  (LW),
    .INDEX_WIDTH (IW),
    .READ_PORTS  (RP)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_read_addr    (raddr),
    .o_read_data    (rdata),
    .i_write_enable (we),
    .i_write_addr   (waddr),
    .i_write_mask   (wmask),
    .i_write_data   (wdata),
    .o_busy         (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: after reset the file is all zero and unusable for DEPTH cycles;
  // afterwards a read shows the entry with this cycle's masked write applied.
  logic [LANES-1:0][LW-1:0]         mmem [DEPTH];
  logic [RP-1:0][LANES-1:0][LW-1:0] exp_rd;
  logic                             exp_busy;
  int                               busy_left = 0;
  bit                               mvalid = 0;

  always @(posedge clk) begin
    if (rst) begin
      mvalid    = 1;
      busy_left = DEPTH;
      for (int e = 0; e < DEPTH; e++) mmem[e] = '0;
      exp_rd    = '0;
    end else if (mvalid) begin
      if (busy_left > 0) begin
        busy_left = busy_left - 1;
        exp_rd    = '0;
      end else begin
        if (we)
          for (int k = 0; k < LANES; k++)
            if (wmask[k]) mmem[waddr][k] = wdata[k];
        for (int p = 0; p < RP; p++) exp_rd[p] = mmem[raddr[p]];
      end
    end
    exp_busy = (busy_left > 0);
  end

  always @(negedge clk) begin
    if (mvalid) begin
      n_cmp++;
      if (busy !== exp_busy) begin
        n_bad++;
        $display("FAIL model_busy t=%0t: got %b expected %b", $time, busy, exp_busy);
      end
      n_cmp++;
      if (rdata !== exp_rd) begin
        n_bad++;
        $display("FAIL model_rdata t=%0t: got %h expected %h", $time, rdata, exp_rd);
      end
    end
  end

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic do_write(input logic [IW-1:0] a, input logic [LANES-1:0] m,
                          input logic [LW-1:0] base, input bit add_lane);
    we    = 1'b1;
    waddr = a;
    wmask = m;
    for (int k = 0; k < LANES; k++) wdata[k] = add_lane ? base + LW'(k) : base;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int n;

  initial begin
    rst   = 1'b1;
    we    = 1'b0;
    waddr = '0;
    wmask = '0;
    wdata = '0;
    raddr = '0;
    tick();
    tick();
    chk("reset_busy", LW'(busy), 32'd1);
    chk("reset_rdata0", rdata[0][0], 32'd0);
    rst = 1'b0;
    count_busy(n);
    chk("clear_len", n, 32'd8);

    for (int a = 0; a < DEPTH; a++) begin
      raddr[0] = IW'(a);
      raddr[1] = IW'(DEPTH - 1 - a);
      tick();
      chk("idle_read", rdata[0][a] | rdata[1][LANES-1-a], 32'd0);
    end

    do_write(3, 16'hFFFF, 32'h1000, 1);
    tick();
    we = 1'b0;
    raddr[0] = 3;
    raddr[1] = 3;
    tick();
    for (int k = 0; k < LANES; k++) begin
      chk("full_p0", rdata[0][k], 32'h1000 + k);
      chk("full_p1", rdata[1][k], 32'h1000 + k);
    end

    do_write(3, 16'h00F0, 32'hAAAA_AAAA, 0);
    tick();
    we = 1'b0;
    tick();
    for (int k = 0; k < LANES; k++)
      chk("partial", rdata[0][k], (k >= 4 && k <= 7) ? 32'hAAAA_AAAA : 32'h1000 + k);

    do_write(5, 16'hFFFF, 32'h55, 0);
    raddr[0] = 5;
    raddr[1] = 4;
    tick();
    we = 1'b0;
    chk("fwd_p0_l0", rdata[0][0], 32'h55);
    chk("fwd_p0_l15", rdata[0][15], 32'h55);
    chk("fwd_p1", rdata[1][9], 32'h0);

    do_write(3, 16'h0000, 32'hDEAD_BEEF, 0);
    raddr[0] = 3;
    tick();
    we = 1'b0;
    chk("mask0_noop", rdata[0][5], 32'hAAAA_AAAA);

    do_write(6, 16'h8001, 32'h77, 0);
    raddr[1] = 6;
    tick();
    we = 1'b0;
    chk("fwd_mask_l0", rdata[1][0], 32'h77);
    chk("fwd_mask_l1", rdata[1][1], 32'h0);

    pulse_reset();
    tick();
    tick();
    do_write(2, 16'hFFFF, 32'hFF, 0);
    tick();
    we = 1'b0;
    count_busy(n);
    chk("clear_done", LW'(busy), 32'd0);
    raddr[0] = 2;
    tick();
    chk("clear_write_ignored", rdata[0][0], 32'h0);

    for (int a = 0; a < DEPTH; a++) begin
      do_write(IW'(a), 16'hFFFF, 32'h100 * (a + 1), 1);
      tick();
    end
    we = 1'b0;
    raddr[0] = 7;
    raddr[1] = 0;
    tick();
    chk("populate7", rdata[0][2], 32'h802);
    chk("populate0", rdata[1][2], 32'h102);
    pulse_reset();
    tick();
    tick();
    tick();
    pulse_reset();
    count_busy(n);
    chk("reclear_len", n, 32'd8);
    for (int a = 0; a < DEPTH; a++) begin
      raddr[0] = IW'(a);
      raddr[1] = IW'(a);
      tick();
      chk("after_reset_read", rdata[0][a] | rdata[1][LANES-1-a], 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_regfile.md
# vec_regfile

Parametrised vector register file, successor to the fixed two-port vector RAM. Holds 2^INDEX_WIDTH vectors of LANES × LANE_WIDTH bits. Serves READ_PORTS independent registered read ports and one write port with per-lane write mask. Same-cycle write-to-read forwarding and a hardware clear sequence after reset. Sits between the vector decode stage (read operands) and vector writeback.

## Interface
- LANES, 16, lanes per vector
- LANE_WIDTH, 32, bits per lane
- INDEX_WIDTH, 3, register index width; DEPTH = 2^INDEX_WIDTH
- READ_PORTS, 2, number of read ports (≥1)

Ports:
- i_clk  in  1  clock; all state changes on posedge
- i_rst  in  1  reset; synchronous and active-high
- i_read_addr  in  [READ_PORTS][INDEX_WIDTH]  read index per port
- o_read_data  out  [READ_PORTS][LANES][LANE_WIDTH]  registered read data per port
- i_write_enable  in  1  write strobe
- i_write_addr  in  INDEX_WIDTH  write index
- i_write_mask  in  LANES  per-lane write enable; bit k gates lane k
- i_write_data  in  [LANES][LANE_WIDTH]  write data
- o_busy  out  1  high while clear sequence runs; writes ignored, reads return 0

## Operation
- FSM states: CLEAR, READY.
- Reset:
  - State ← CLEAR, clear counter ← 0, o_busy ← 1, every o_read_data ← 0.
  - i_rst high in any state, including mid-CLEAR, restarts from entry 0.
- CLEAR:
  - Each cycle, write all-zero vector to entry counter; counter increments.
  - After entry DEPTH-1 is written, next state is READY and o_busy ← 0.
  - i_write_enable is ignored; read outputs are held 0.
- READY, write:
  - On posedge with i_write_enable=1, lane k of entry i_write_addr ← i_write_data[k] iff i_write_mask[k]=1; other lanes unchanged.
  - i_write_mask=0 with enable=1 is a no-op.
- READY, read:
  - Each port p samples i_read_addr[p] on every posedge.
  - o_read_data[p] holds that entry's content as of the end of that cycle.
- Forwarding: if port p's sampled address equals i_write_addr with enable high in the same cycle, masked lanes show the new data and unmasked lanes show the old. There is no stale-read window.
- Ports are fully independent; any number may read the same address.
- Addresses always in range (power-of-two depth); no wrap handling needed.

## Timing
- Read latency: 1 cycle. Address presented in cycle N gives data on o_read_data in cycle N+1.
- Output holds until the next posedge; no enable or valid strobe.
- Write latency: 1 cycle. Written in cycle N, it is visible to a read addressed in N, observed in N+1, through forwarding.
- Clear duration: o_busy high for exactly DEPTH cycles after the cycle in which i_rst is deasserted (8 for defaults).
  - First accepted write is in cycle DEPTH after that deassertion.
  - First nonzero read data appears at DEPTH+1.
- All logic posedge; no negedge sampling.

## Structure
- Package vec_pkg:
  - LANES and LANE_WIDTH defaults
  - typedef vec_lane_t (LANE_WIDTH bits)
  - typedef vec_t (LANES × vec_lane_t)
  - typedef vec_mask_t (LANES bits)
  - FSM enum vec_rf_state_e {CLEAR, READY}
- Sub-module vec_lane_bank:
  - DEPTH × LANE_WIDTH storage with READ_PORTS registered reads, one write port and forwarding.
  - Instantiated LANES times; mask bit k drives bank k's write enable.
  - The clear FSM in the top drives all banks' writes during CLEAR.

## Test plan
- Reset then idle: hold i_rst 2 cycles, release.
  - o_busy high for 8 cycles then low.
  - Reading every address 0..7 returns 0 on all ports.
- Full write/read: write entry 3 with lane k = 0x1000+k, mask 0xFFFF. Next cycle read 3 on port 0 and 3 on port 1.
  - Both ports return lanes 0x1000..0x100F.
- Partial mask: entry 3 as above, then write lanes = 0xAAAA_AAAA with mask 0x00F0.
  - Read gives lanes 4–7 = 0xAAAA_AAAA, other lanes unchanged at 0x1000+k.
- Forwarding: same cycle, write entry 5 (all lanes 0x55, mask 0xFFFF) and read 5 on port 0.
  - Next cycle o_read_data[0] = all 0x55.
  - Port 1 reading 4 in the same cycle returns 0.
- Write during clear: assert write of entry 2 = 0xFF in the 3rd busy cycle.
  - After READY, entry 2 reads 0.
- Reset mid-operation: populate entries 0..7, pulse i_rst during READY, then pulse again at busy cycle 4.
  - o_busy stays high 8 cycles after the last deassertion.
  - All entries read 0 afterwards.
